// File: rtl/f1_lights_seq.sv
// f1_lights_seq: F1 start-light sequencer with tick divider, pseudo-random hold and reaction timer
// Ports: clk/rst (sync, active-high), en gates the tick divider, N = tick period - 1,
//        trigger starts a sequence from IDLE, react is the driver button,
//        out = light bar (bit0 first), busy = not IDLE, go = lights-out pulse,
//        false_start = early-react pulse, rt_valid/rt_count = reaction time result.
module f1_lights_seq #(
    parameter int WIDTH   = 16,
    parameter int NLIGHTS = 8,
    parameter int DLY_W   = 4,
    parameter int RT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   N,
    input  logic               trigger,
    input  logic               react,
    output logic [NLIGHTS-1:0] out,
    output logic               busy,
    output logic               go,
    output logic               false_start,
    output logic               rt_valid,
    output logic [RT_W-1:0]    rt_count
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD, TIMING} state_t;
    state_t              state, state_n;
    logic [WIDTH-1:0]    cnt;
    logic [6:0]          lfsr;
    logic [DLY_W-1:0]    dly, dly_n;
    logic [RT_W-1:0]     rtc, rtc_n, rt_count_n;
    logic [NLIGHTS-1:0]  out_n;
    logic                go_n, fs_n, rtv_n, tick, accept;
    assign tick   = en && cnt == '0;
    assign accept = state == IDLE && trigger;
    assign busy   = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out         <= '0;
            go          <= 1'b0;
            false_start <= 1'b0;
            rt_valid    <= 1'b0;
            rt_count    <= '0;
            rtc         <= '0;
            dly         <= '0;
            cnt         <= N;
            lfsr        <= 7'h01;
        end else begin
            state       <= state_n;
            out         <= out_n;
            go          <= go_n;
            false_start <= fs_n;
            rt_valid    <= rtv_n;
            rt_count    <= rt_count_n;
            rtc         <= rtc_n;
            dly         <= dly_n;
            // trigger acceptance restarts the period so the first light is a full tick away
            cnt         <= (accept || tick) ? N : en ? cnt - 1'b1 : cnt;
            // x^7 + x^6 + 1, free-running so the hold delay depends on when the driver starts
            lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end
    always_comb begin
        state_n    = state;
        out_n      = out;
        dly_n      = dly;
        rtc_n      = rtc;
        rt_count_n = rt_count;
        go_n       = 1'b0;
        fs_n       = 1'b0;
        rtv_n      = 1'b0;
        case (state)
            IDLE: state_n = trigger ? FILL : IDLE;
            FILL, HOLD: begin
                // an early react beats a coincident tick
                if (react) begin
                    out_n   = '0;
                    fs_n    = 1'b1;
                    state_n = IDLE;
                end else if (tick && state == FILL) begin
                    out_n = {out[NLIGHTS-2:0], 1'b1};
                    if (&out[NLIGHTS-2:0]) begin
                        state_n = HOLD;
                        dly_n   = lfsr[DLY_W-1:0];
                    end
                end else if (tick) begin
                    if (dly == '0) begin
                        out_n   = '0;
                        go_n    = 1'b1;
                        rtc_n   = '0;
                        state_n = TIMING;
                    end else begin
                        dly_n = dly - 1'b1;
                    end
                end
            end
            TIMING: begin
                if (react) begin
                    rt_count_n = rtc;
                    rtv_n      = 1'b1;
                    state_n    = IDLE;
                end else begin
                    rtc_n = (&rtc) ? rtc : rtc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_f1_lights_seq.sv
// tb_f1_lights_seq: directed and random checks of f1_lights_seq against a light-count reference model
module tb_f1_lights_seq;
    localparam int NL = 8;
    localparam int DW = 4;
    localparam int RW = 16;
    localparam int W  = 16;
    logic          clk = 1'b0, rst = 1'b1, en = 1'b1, trigger = 1'b0, react = 1'b0;
    logic [W-1:0]  n = 16'd3;
    logic [NL-1:0] out;
    logic          busy, go, false_start, rt_valid;
    logic [RW-1:0] rt_count;
    int checks = 0, errors = 0;
    f1_lights_seq #(.WIDTH(W), .NLIGHTS(NL), .DLY_W(DW), .RT_W(RW)) dut (
        .clk(clk), .rst(rst), .en(en), .N(n), .trigger(trigger), .react(react),
        .out(out), .busy(busy), .go(go), .false_start(false_start),
        .rt_valid(rt_valid), .rt_count(rt_count)
    );
    always #5 clk = ~clk;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: phase 0 idle, 1 filling, 2 holding, 3 timing; lights tracked as a count.
    int       m_phase, m_lit, m_hold, m_rtc, m_rt, m_elapsed;
    bit       m_go, m_fs, m_rtv, armed = 0, tk, acc;
    logic [6:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_lit = 0; m_hold = 0; m_rtc = 0; m_rt = 0; m_elapsed = 0;
            m_go = 0; m_fs = 0; m_rtv = 0; m_lfsr = 7'h01; armed = 1;
        end else begin
            tk  = en && m_elapsed == int'(n);
            acc = m_phase == 0 && trigger;
            m_go = 0; m_fs = 0; m_rtv = 0;
            if (m_phase == 0) begin
                if (trigger) m_phase = 1;
            end else if (m_phase < 3) begin
                if (react) begin
                    m_lit = 0; m_fs = 1; m_phase = 0;
                end else if (tk && m_phase == 1) begin
                    m_lit++;
                    if (m_lit == NL) begin
                        m_phase = 2;
                        m_hold  = int'(m_lfsr[DW-1:0]);
                    end
                end else if (tk) begin
                    if (m_hold == 0) begin
                        m_lit = 0; m_go = 1; m_rtc = 0; m_phase = 3;
                    end else m_hold--;
                end
            end else if (react) begin
                m_rt = m_rtc; m_rtv = 1; m_phase = 0;
            end else if (m_rtc < (1 << RW) - 1) m_rtc++;
            if (acc) m_elapsed = 0;
            else if (en) m_elapsed = tk ? 0 : m_elapsed + 1;
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            check("out", 32'(out), (1 << m_lit) - 1);
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("go", 32'(go), 32'(m_go));
            check("false_start", 32'(false_start), 32'(m_fs));
            check("rt_valid", 32'(rt_valid), 32'(m_rtv));
            check("rt_count", 32'(rt_count), m_rt);
        end
    end
    initial begin
        int k, d;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rt_count", 32'(rt_count), 0);
        rst = 1'b0;
        react = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_react_fs", 32'(false_start), 0);
        check("idle_react_busy", 32'(busy), 0);
        react = 1'b0;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        for (int i = 0; i < NL; i++) begin
            repeat (4) @(negedge clk);
            check("fill_step", 32'(out), (1 << (i + 1)) - 1);
        end
        d = m_hold;
        k = 0;
        while (go !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("go_delay", k, 4 * (d + 1));
        repeat (5) @(negedge clk);
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
        check("rt_valid_5", 32'(rt_valid), 1);
        check("rt_count_5", 32'(rt_count), 5);
        check("rt_busy", 32'(busy), 0);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        k = 0;
        while (out !== 8'h07 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_07", 32'(out), 32'h07);
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
        check("fs_pulse", 32'(false_start), 1);
        check("fs_out", 32'(out), 0);
        check("fs_busy", 32'(busy), 0);
        check("fs_rt_keep", 32'(rt_count), 5);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        k = 0;
        while (out !== 8'h03 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            trigger = (i == 4);
            @(negedge clk);
            check("frozen", 32'(out), 32'h03);
        end
        trigger = 1'b0;
        en = 1'b1;
        k = 0;
        while (out !== 8'h07 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("resume_ticks", k, 3);
        k = 0;
        while (out !== 8'hFF && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_ff", 32'(out), 32'hFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hold_rst_out", 32'(out), 0);
        check("hold_rst_busy", 32'(busy), 0);
        check("hold_rst_go", 32'(go), 0);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        k = 0;
        while (go !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("go_seen", 32'(go), 1);
        repeat (65540) @(negedge clk);
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
        check("rt_saturate", 32'(rt_count), 32'hFFFF);
        check("rt_saturate_valid", 32'(rt_valid), 1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = $urandom_range(0, 199) == 0;
            if (rst) n = W'($urandom_range(0, 3));
            en = $urandom_range(0, 9) != 0;
            trigger = $urandom_range(0, 19) == 0;
            react = $urandom_range(0, 29) == 0;
        end
        rst = 1'b0;
        trigger = 1'b0;
        react = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
